// File: rtl/tinker_mem_arbiter.sv
// rtl/tinker_mem_arbiter.sv - fetch/data arbiter and fixed-latency access sequencer for one memory port
module tinker_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [63:0]       d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [63:0]       d_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_t              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic                drop_q, drop_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [63:0]         mem_wdata_q, mem_wdata_d;
  logic                if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0]         if_rsp_data_q, if_rsp_data_d;
  logic                d_rsp_valid_q, d_rsp_valid_d;
  logic [63:0]         d_rsp_rdata_q, d_rsp_rdata_d;
  logic                busy_q, busy_d;

  logic                idle;
  logic                fetch_starved;
  logic                data_wins;
  logic                d_accept;
  logic                f_accept;

  // Grant: data has priority unless fetch has been passed over STARVE_LIMIT times in a row
  always_comb begin
    idle          = (state_q == S_IDLE);
    fetch_starved = if_req_valid & (starve_cnt_q == LIMIT);
    data_wins     = d_req_valid & ~fetch_starved;
    d_req_ready   = idle & data_wins;
    if_req_ready  = idle & if_req_valid & ~data_wins;
    d_accept      = d_req_valid & d_req_ready;
    f_accept      = if_req_valid & if_req_ready;
  end

  // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/RESP sequence
  always_comb begin
    state_d        = state_q;
    starve_cnt_d   = starve_cnt_q;
    lat_cnt_d      = lat_cnt_q;
    drop_d         = drop_q;
    owner_d        = owner_q;
    we_d           = we_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    d_rsp_valid_d  = 1'b0;
    d_rsp_rdata_d  = d_rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (d_accept) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_DATA;
          we_d        = d_req_we;
          drop_d      = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = d_req_we;
          mem_addr_d  = d_req_addr;
          mem_wdata_d = d_req_wdata;
          if (if_req_valid && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (f_accept) begin
          state_d      = S_ISSUE;
          owner_d      = OWN_FETCH;
          we_d         = 1'b0;
          drop_d       = if_flush;
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_req_addr;
          mem_wdata_d  = 64'd0;
          starve_cnt_d = 4'd0;
        end
      end
      S_ISSUE: begin
        state_d   = S_WAIT;
        lat_cnt_d = LAT_M1;
      end
      S_WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (owner_q == OWN_DATA) begin
            d_rsp_valid_d = 1'b1;
            d_rsp_rdata_d = we_q ? 64'd0 : mem_rdata;
          end else begin
            // A flush arriving in this very cycle must also cancel the pulse
            if_rsp_valid_d = ~(drop_q | if_flush);
            if_rsp_data_d  = mem_rdata[31:0];
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush only affects an outstanding fetch; the memory access itself still completes
    if ((state_q != S_IDLE) && (owner_q == OWN_FETCH) && if_flush) begin
      drop_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      starve_cnt_q   <= 4'd0;
      lat_cnt_q      <= 4'd0;
      drop_q         <= 1'b0;
      owner_q        <= 1'b0;
      we_q           <= 1'b0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 64'd0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= 32'd0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_rdata_q  <= 64'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_cnt_q   <= starve_cnt_d;
      lat_cnt_q      <= lat_cnt_d;
      drop_q         <= drop_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_rdata_q  <= d_rsp_rdata_d;
      busy_q         <= busy_d;
    end
  end

  // Drive outputs; the fetch pulse is gated by a flush seen during the RESP cycle itself
  always_comb begin
    mem_en       = mem_en_q;
    mem_we       = mem_we_q;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    if_rsp_valid = if_rsp_valid_q & ~if_flush;
    if_rsp_data  = if_rsp_data_q;
    d_rsp_valid  = d_rsp_valid_q;
    d_rsp_rdata  = d_rsp_rdata_q;
    busy         = busy_q;
    owner        = owner_q;
  end

endmodule

// File: doc/tinker_mem_arbiter.md
# tinker_mem_arbiter

Single-port memory arbiter and access sequencer for the pipelined Tinker core. It shares one byte-addressed memory port between the instruction-fetch stage and the data stage (load, store, call push, return pop). It sequences each access through a fixed-latency memory, returns responses on per-requester valid pulses, and bounds fetch starvation with a counter. It sits between the core's IF/MEM stages and the memory array.

## Interface
- ADDR_W, 32, byte address width
- MEM_LATENCY, 2, cycles from mem_en cycle to mem_rdata valid; legal range 1..15
- STARVE_LIMIT, 4, consecutive data grants (with fetch waiting) before fetch is forced; legal range 1..15

Ports (reset, asynchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch accepted this cycle when valid&ready
- if_flush  in  1  drop any outstanding fetch response
- if_rsp_valid  out  1  one-cycle fetch response pulse
- if_rsp_data  out  32  instruction = captured mem_rdata[31:0]
- d_req_valid  in  1  data request
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  64  store data
- d_req_ready  out  1  data accepted this cycle when valid&ready
- d_rsp_valid  out  1  one-cycle data response/ack pulse
- d_rsp_rdata  out  64  load data; 0 for store acks
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  read data, valid MEM_LATENCY cycles after mem_en cycle
- busy  out  1  state != IDLE
- owner  out  1  0 = fetch, 1 = data; owner of current/last access

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: grant computed combinationally from the valids:
  - data wins if d_req_valid, unless if_req_valid and starve_cnt == STARVE_LIMIT;
  - otherwise fetch wins if if_req_valid.
  - Only the granted requester sees ready=1. Neither ready is high outside IDLE.
- Accept (valid & ready):
  - latch addr, we, wdata and owner;
  - load drop flag = if_flush & (owner==fetch);
  - go to ISSUE.
- ISSUE: mem_en=1, mem_we/mem_addr/mem_wdata from the latched request, for one cycle. Then WAIT with the counter loaded to MEM_LATENCY-1.
- WAIT: lasts exactly MEM_LATENCY cycles; counter decrements each cycle. On the edge leaving WAIT at counter==0, capture mem_rdata. Then RESP.
- RESP: one cycle, then IDLE.
  - owner=data: d_rsp_valid=1, d_rsp_rdata = captured data (loads) or 0 (stores).
  - owner=fetch: if_rsp_valid = ~drop, if_rsp_data = captured[31:0].
- if_flush high in any ISSUE/WAIT/RESP cycle with owner=fetch sets drop. A flush in RESP suppresses that same cycle's pulse. The memory access still completes.
- starve_cnt (4 bits):
  - +1, saturating at STARVE_LIMIT, on each data accept while if_req_valid=1;
  - cleared on every fetch accept;
  - unchanged otherwise.
- Requesters may withdraw valid before accept; only the accept cycle is sampled.
- No address alignment checks; addresses pass through unmodified.

## Timing
- Accept at cycle T: mem_en at T+1, mem_rdata valid at T+1+MEM_LATENCY, rsp pulse at T+2+MEM_LATENCY, next accept earliest T+3+MEM_LATENCY.
- All outputs except the readys are registered. Readys are combinational from state, valids and starve_cnt.
- Reset values (immediate on reset assertion): state IDLE, starve_cnt 0, drop 0, owner 0, mem_en/mem_we 0, mem_addr/mem_wdata 0, rsp valids 0, rsp data 0, busy 0.
- Reset mid-access: in-flight access abandoned; no response pulse after reset release.
- Both valids high in IDLE with starve_cnt < STARVE_LIMIT: data granted.
- if_flush while owner=data: no effect.

## Test plan
- Single load, MEM_LATENCY=2, d_req at 0x100 accepted at T, memory returns 0xDEADBEEF_CAFEF00D -> mem_en at T+1 only, d_rsp_valid only at T+4 with that data, busy T+1..T+4.
- Store 0x11223344_55667788 to 0x80 -> one mem_en cycle with mem_we=1, addr 0x80, wdata matching; d_rsp_valid at T+4 with rdata 0.
- Fetch and data both held valid continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt returns to 0 after each F.
- Fetch accepted at T, if_flush pulsed at T+2 -> if_rsp_valid never asserted; next request accepted at T+5.
- Fetch to 0x2000, memory returns 0x0000_0000_7800_0000 -> if_rsp_valid at T+4, if_rsp_data 0x78000000.
- Reset asserted during WAIT -> all outputs 0 immediately; no rsp pulse after release; first accept succeeds normally.
